// File: rtl/rename_regfile_pkg.sv
// Shared widths and small helpers for the rename register file.
package rename_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // x0 is hard-wired to zero and never renamed.
    function automatic logic is_x0(input logic [REG_W-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/rename_regfile_operand_lookup.sv
// Resolves one source operand: ready value from the register file, a value
// forwarded by the ROB, or the tag of the ROB entry that will produce it.
module rename_regfile_operand_lookup
    import rename_regfile_pkg::*;
#(
    parameter int ROB_W = 4
) (
    input  logic [REG_W-1:0]  idx,
    input  logic              busy,
    input  logic [DATA_W-1:0] value,
    input  logic [ROB_W-1:0]  reg_tag,
    input  logic              fwd_rdy,
    input  logic [DATA_W-1:0] fwd_val,
    output logic              rdy,
    output logic [DATA_W-1:0] val,
    output logic [ROB_W-1:0]  src_tag
);

    assign src_tag = reg_tag;

    // Priority: x0, architectural value, ROB forward, otherwise wait on tag.
    always_comb begin
        rdy = 1'b1;
        val = '0;
        if (is_x0(idx)) begin
            rdy = 1'b1;
            val = '0;
        end else if (!busy) begin
            rdy = 1'b1;
            val = value;
        end else if (fwd_rdy) begin
            rdy = 1'b1;
            val = fwd_val;
        end else begin
            rdy = 1'b0;
            val = '0;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename state. Issue reads
// two operands and renames its destination; ROB commit retires values and
// clears rename state when the committing tag is still the live mapping;
// a mispredict flush drops every in-flight rename. NREG must not exceed 32.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int ROB_W = 4,
    parameter int NREG  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              IS_sgn,
    input  logic [REG_W-1:0]  IS_rs1,
    input  logic [REG_W-1:0]  IS_rs2,
    input  logic [REG_W-1:0]  IS_rd,
    output logic              IS_rdy1,
    output logic              IS_rdy2,
    output logic [DATA_W-1:0] IS_val1,
    output logic [DATA_W-1:0] IS_val2,
    output logic [ROB_W-1:0]  IS_tag1,
    output logic [ROB_W-1:0]  IS_tag2,
    input  logic [ROB_W-1:0]  ROB_name,
    output logic [ROB_W-1:0]  REG_ord1,
    output logic [ROB_W-1:0]  REG_ord2,
    input  logic              REG_rdy1,
    input  logic              REG_rdy2,
    input  logic [DATA_W-1:0] REG_val1,
    input  logic [DATA_W-1:0] REG_val2,
    input  logic              REG_commit_sgn,
    input  logic [REG_W-1:0]  REG_commit_dest,
    input  logic [DATA_W-1:0] REG_commit_value,
    input  logic [ROB_W-1:0]  REG_commit_ROB_name,
    input  logic              jp_wrong
);

    logic [DATA_W-1:0] value [NREG];
    logic [ROB_W-1:0]  tag   [NREG];
    logic [NREG-1:0]   busy;

    logic issue_en;
    logic commit_en;
    logic flush_en;

    assign issue_en  = rdy && IS_sgn && !jp_wrong && !is_x0(IS_rd);
    assign commit_en = rdy && REG_commit_sgn && !is_x0(REG_commit_dest);
    assign flush_en  = rdy && jp_wrong;

    // The ROB is asked about whatever tag each source currently maps to.
    assign REG_ord1 = tag[IS_rs1];
    assign REG_ord2 = tag[IS_rs2];

    rename_regfile_operand_lookup #(.ROB_W(ROB_W)) u_lookup1 (
        .idx     (IS_rs1),
        .busy    (busy[IS_rs1]),
        .value   (value[IS_rs1]),
        .reg_tag (tag[IS_rs1]),
        .fwd_rdy (REG_rdy1),
        .fwd_val (REG_val1),
        .rdy     (IS_rdy1),
        .val     (IS_val1),
        .src_tag (IS_tag1)
    );

    rename_regfile_operand_lookup #(.ROB_W(ROB_W)) u_lookup2 (
        .idx     (IS_rs2),
        .busy    (busy[IS_rs2]),
        .value   (value[IS_rs2]),
        .reg_tag (tag[IS_rs2]),
        .fwd_rdy (REG_rdy2),
        .fwd_val (REG_val2),
        .rdy     (IS_rdy2),
        .val     (IS_val2),
        .src_tag (IS_tag2)
    );

    // Register state update: commit value always lands; a new issue to the
    // same register wins busy/tag over a same-cycle commit; flush wins all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int r = 0; r < NREG; r++) begin
                value[r] <= '0;
                tag[r]   <= '0;
            end
        end else if (rdy) begin
            for (int r = 1; r < NREG; r++) begin
                if (commit_en && REG_commit_dest == REG_W'(r)) begin
                    value[r] <= REG_commit_value;
                end
                if (flush_en) begin
                    busy[r] <= 1'b0;
                end else if (issue_en && IS_rd == REG_W'(r)) begin
                    busy[r] <= 1'b1;
                    tag[r]  <= ROB_name;
                end else if (commit_en && REG_commit_dest == REG_W'(r)
                             && tag[r] == REG_commit_ROB_name) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Bench for rename_regfile: a reference model of register state produces
// expected lookups, queued at drive time and compared once outputs settle.
module tb_rename_regfile;

    localparam int ROB_W = 4;
    localparam int NREG  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        IS_sgn;
    logic [4:0]  IS_rs1, IS_rs2, IS_rd;
    logic        IS_rdy1, IS_rdy2;
    logic [31:0] IS_val1, IS_val2;
    logic [3:0]  IS_tag1, IS_tag2;
    logic [3:0]  ROB_name;
    logic [3:0]  REG_ord1, REG_ord2;
    logic        REG_rdy1, REG_rdy2;
    logic [31:0] REG_val1, REG_val2;
    logic        REG_commit_sgn;
    logic [4:0]  REG_commit_dest;
    logic [31:0] REG_commit_value;
    logic [3:0]  REG_commit_ROB_name;
    logic        jp_wrong;

    rename_regfile #(.ROB_W(ROB_W), .NREG(NREG)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .IS_sgn              (IS_sgn),
        .IS_rs1              (IS_rs1),
        .IS_rs2              (IS_rs2),
        .IS_rd               (IS_rd),
        .IS_rdy1             (IS_rdy1),
        .IS_rdy2             (IS_rdy2),
        .IS_val1             (IS_val1),
        .IS_val2             (IS_val2),
        .IS_tag1             (IS_tag1),
        .IS_tag2             (IS_tag2),
        .ROB_name            (ROB_name),
        .REG_ord1            (REG_ord1),
        .REG_ord2            (REG_ord2),
        .REG_rdy1            (REG_rdy1),
        .REG_rdy2            (REG_rdy2),
        .REG_val1            (REG_val1),
        .REG_val2            (REG_val2),
        .REG_commit_sgn      (REG_commit_sgn),
        .REG_commit_dest     (REG_commit_dest),
        .REG_commit_value    (REG_commit_value),
        .REG_commit_ROB_name (REG_commit_ROB_name),
        .jp_wrong            (jp_wrong)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r1;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic        r2;
        logic [31:0] v2;
        logic [3:0]  t2;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_val  [NREG];
    logic        m_busy [NREG];
    logic [3:0]  m_tag  [NREG];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_val[r]  = '0;
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
    endtask

    function automatic void ref_lookup(input logic [4:0] rs, input logic fr, input logic [31:0] fv,
                                       output logic r, output logic [31:0] v, output logic [3:0] t);
        t = m_tag[rs];
        if (rs == 5'd0)        begin r = 1'b1; v = 32'd0;     end
        else if (!m_busy[rs])  begin r = 1'b1; v = m_val[rs]; end
        else if (fr)           begin r = 1'b1; v = fv;        end
        else                   begin r = 1'b0; v = 32'd0;     end
    endfunction

    // Clock-edge effect of the currently driven inputs on the model.
    task automatic m_update();
        logic iss, com, fl;
        iss = rdy && IS_sgn && !jp_wrong && (IS_rd != 5'd0);
        com = rdy && REG_commit_sgn && (REG_commit_dest != 5'd0);
        fl  = rdy && jp_wrong;
        if (com) begin
            if (m_tag[REG_commit_dest] == REG_commit_ROB_name && !(iss && IS_rd == REG_commit_dest))
                m_busy[REG_commit_dest] = 1'b0;
            m_val[REG_commit_dest] = REG_commit_value;
        end
        if (fl) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end else if (iss) begin
            m_busy[IS_rd] = 1'b1;
            m_tag[IS_rd]  = ROB_name;
        end
    endtask

    task automatic sample(input string name);
        exp_t e;
        logic r;
        logic [31:0] v;
        logic [3:0] t;
        ref_lookup(IS_rs1, REG_rdy1, REG_val1, r, v, t);
        e.r1 = r; e.v1 = v; e.t1 = t;
        ref_lookup(IS_rs2, REG_rdy2, REG_val2, r, v, t);
        e.r2 = r; e.v2 = v; e.t2 = t;
        sb.push_back(e);
        e = sb.pop_front();
        chk({name, ".rdy1"}, 32'(IS_rdy1), 32'(e.r1));
        chk({name, ".val1"}, IS_val1, e.v1);
        chk({name, ".ord1"}, 32'(REG_ord1), 32'(e.t1));
        if (!e.r1) chk({name, ".tag1"}, 32'(IS_tag1), 32'(e.t1));
        chk({name, ".rdy2"}, 32'(IS_rdy2), 32'(e.r2));
        chk({name, ".val2"}, IS_val2, e.v2);
        chk({name, ".ord2"}, 32'(REG_ord2), 32'(e.t2));
        if (!e.r2) chk({name, ".tag2"}, 32'(IS_tag2), 32'(e.t2));
    endtask

    // Inputs are driven just after a falling edge; check, then clock once.
    task automatic cyc(input string name);
        #2;
        sample(name);
        @(posedge clk);
        if (rst) m_update();
        else     m_reset();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy = 1'b1; IS_sgn = 1'b0; IS_rs1 = '0; IS_rs2 = '0; IS_rd = '0;
        ROB_name = '0; REG_rdy1 = 1'b0; REG_rdy2 = 1'b0; REG_val1 = '0; REG_val2 = '0;
        REG_commit_sgn = 1'b0; REG_commit_dest = '0; REG_commit_value = '0;
        REG_commit_ROB_name = '0; jp_wrong = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] name);
        idle(); IS_sgn = 1'b1; IS_rd = rd; ROB_name = name;
    endtask

    task automatic commit(input logic [4:0] dest, input logic [3:0] name, input logic [31:0] val);
        REG_commit_sgn = 1'b1; REG_commit_dest = dest;
        REG_commit_ROB_name = name; REG_commit_value = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        idle();
        m_reset();
        IS_rs1 = 5'd5;
        repeat (2) @(negedge clk);
        cyc("reset");
        rst = 1'b1;

        // Reset state through an issue-side read of x5 and x0.
        idle(); IS_sgn = 1'b1; IS_rs1 = 5'd5; IS_rs2 = 5'd0; cyc("rd_after_reset");

        // Rename x3 -> 7, then a pending read, then a ROB forward.
        issue(5'd3, 4'd7);                         cyc("issue_x3");
        idle(); IS_rs1 = 5'd3;                     cyc("x3_pending");
        idle(); IS_rs1 = 5'd3; REG_rdy1 = 1'b1; REG_val1 = 32'h55; cyc("x3_forward");

        // Commit of the live tag clears busy.
        idle(); IS_rs1 = 5'd3; commit(5'd3, 4'd7, 32'hABCD); cyc("commit_x3");
        idle(); IS_rs1 = 5'd3; IS_rs2 = 5'd3;      cyc("x3_retired");

        // Stale commit: value written, busy kept with the newer tag.
        issue(5'd3, 4'd7);                         cyc("x3_tag7");
        issue(5'd3, 4'd9);                         cyc("x3_tag9");
        idle(); commit(5'd3, 4'd7, 32'h1111);      cyc("stale_commit");
        idle(); IS_rs1 = 5'd3; IS_rs2 = 5'd3; REG_rdy2 = 1'b1; REG_val2 = 32'h22; cyc("x3_still_busy");

        // Same-cycle commit and issue to x4.
        issue(5'd4, 4'd2);                         cyc("x4_tag2");
        issue(5'd4, 4'd5); commit(5'd4, 4'd2, 32'h4444); cyc("x4_commit_issue");
        idle(); IS_rs1 = 5'd4;                     cyc("x4_tag5");

        // Frozen cycle: nothing may change while rdy is low.
        issue(5'd10, 4'd3); commit(5'd4, 4'd5, 32'hDEAD); rdy = 1'b0; cyc("frozen");
        idle(); IS_rs1 = 5'd10; IS_rs2 = 5'd4;     cyc("after_frozen");

        // Flush with a concurrent issue to x8.
        issue(5'd1, 4'd1);                         cyc("x1");
        issue(5'd2, 4'd2);                         cyc("x2");
        issue(5'd6, 4'd6);                         cyc("x6");
        issue(5'd8, 4'd8); jp_wrong = 1'b1; IS_rs1 = 5'd1; cyc("flush");
        idle(); IS_rs1 = 5'd1; IS_rs2 = 5'd2;      cyc("flush_x1_x2");
        idle(); IS_rs1 = 5'd6; IS_rs2 = 5'd8;      cyc("flush_x6_x8");
        idle(); IS_rs1 = 5'd4; IS_rs2 = 5'd3;      cyc("flush_x4_x3");

        // x0 is never renamed or written.
        issue(5'd0, 4'd4); commit(5'd0, 4'd4, 32'hFFFF); cyc("x0_write");
        idle(); IS_rs1 = 5'd0;                     cyc("x0_read");

        // Randomised traffic over a few registers to force collisions.
        for (int i = 0; i < 300; i++) begin
            logic [4:0] d;
            idle();
            rdy      = ($urandom_range(0, 9) != 0);
            IS_sgn   = 1'($urandom_range(0, 1));
            IS_rs1   = 5'($urandom_range(0, 7));
            IS_rs2   = 5'($urandom_range(0, 7));
            IS_rd    = 5'($urandom_range(0, 7));
            ROB_name = 4'($urandom_range(0, 15));
            REG_rdy1 = 1'($urandom_range(0, 1));
            REG_rdy2 = 1'($urandom_range(0, 1));
            REG_val1 = $urandom;
            REG_val2 = $urandom;
            d = 5'($urandom_range(0, 7));
            commit(d, ($urandom_range(0, 3) != 0) ? m_tag[d] : 4'($urandom_range(0, 15)), $urandom);
            REG_commit_sgn = 1'($urandom_range(0, 1));
            jp_wrong = ($urandom_range(0, 19) == 0);
            cyc("rnd");
        end

        // Asynchronous reset between clock edges.
        issue(5'd5, 4'd3);                         cyc("x5_rename");
        idle(); IS_rs1 = 5'd5; IS_rs2 = 5'd4;
        #1;
        rst = 1'b0;
        #1;
        m_reset();
        sample("async_reset");
        @(negedge clk);
        rst = 1'b1;
        idle(); IS_rs1 = 5'd5; IS_rs2 = 5'd3;      cyc("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with per-register rename status for the Tomasulo core. It sits between Issue and the ROB. Issue reads two source operands as either a ready value or a ROB tag, and renames the destination to the ROB entry being allocated. The ROB commit port writes retired values back and clears rename state. A mispredict flush drops all in-flight renames.

## Interface
Parameters:
- `ROB_W`, default 4: ROB tag width; matches `ROBID`.
- `NREG`, default 32: architectural register count; x0 is hard-wired to zero.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `rdy`, in, 1: global enable; when low, all state holds.
- `IS_sgn`, in, 1: issue valid this cycle.
- `IS_rs1`, `IS_rs2`, `IS_rd`, in, 5 each: source and destination register indices.
- `IS_rdy1`, `IS_rdy2`, out, 1 each: source operand value is available.
- `IS_val1`, `IS_val2`, out, 32 each: operand value; valid when the matching `IS_rdy` is high.
- `IS_tag1`, `IS_tag2`, out, `ROB_W` each: producing ROB entry; valid when the matching `IS_rdy` is low.
- `ROB_name`, in, `ROB_W`: ROB tag being allocated (ROB rear).
- `REG_ord1`, `REG_ord2`, out, `ROB_W` each: tags looked up in the ROB.
- `REG_rdy1`, `REG_rdy2`, in, 1 each: ROB readiness for `REG_ord1` / `REG_ord2`.
- `REG_val1`, `REG_val2`, in, 32 each: ROB values for `REG_ord1` / `REG_ord2`.
- `REG_commit_sgn`, in, 1: commit writes a register this cycle.
- `REG_commit_dest`, in, 5: destination register of the commit.
- `REG_commit_value`, in, 32: value being committed.
- `REG_commit_ROB_name`, in, `ROB_W`: ROB tag of the committing entry.
- `jp_wrong`, in, 1: mispredict flush.

## Operation
State per register r:
- `value[r]` (32 b), `busy[r]` (1 b), `tag[r]` (`ROB_W` b).

Operand lookup, combinational, shown for source 1 (source 2 is identical):
- `REG_ord1 = tag[IS_rs1]`.
- If `IS_rs1 == 0`: rdy=1, val=0.
- Else if `!busy[IS_rs1]`: rdy=1, val=`value[IS_rs1]`.
- Else if `REG_rdy1`: rdy=1, val=`REG_val1` (ROB forward).
- Else: rdy=0, tag=`tag[IS_rs1]`; val is don't-care and driven 0.
- Lookup always sees pre-issue state. A source equal to `IS_rd` in the same issue reads the old mapping.

Issue, at the edge when `rdy && IS_sgn && !jp_wrong && IS_rd != 0`:
- `busy[IS_rd] <= 1`, `tag[IS_rd] <= ROB_name`.

Commit, at the edge when `rdy && REG_commit_sgn && REG_commit_dest != 0`:
- `value[dest] <= REG_commit_value`.
- `busy[dest] <= 0` only if `tag[dest] == REG_commit_ROB_name` and there is no same-cycle issue to the same rd.

Flush, at the edge when `rdy && jp_wrong`:
- All `busy <= 0`. The commit value write in the same cycle still happens; issue in the same cycle is ignored.

Reset: all `value`, `busy` and `tag` clear to 0. All `IS_rdy` outputs then read 1 with val 0, and `REG_ord1/2` read 0.

## Timing
- Lookups are zero-latency combinational.
- Issue and commit effects are visible on the cycle after the edge.
- Simultaneous issue and commit to the same rd: `value` takes the commit, while `busy`/`tag` take the new issue.
- Commit whose tag no longer matches: write the value, keep `busy`.
- `rdy` low: freeze all state; outputs still reflect current state.
- Reset asserted mid-operation clears state immediately, independent of `clk`.
- x0 is never written or renamed.

## Structure
- `defines.v` supplies `ROBID`, `REGID`, `True`, and `False`; no new package is needed.
- One natural sub-module is `operand_lookup`, instantiated twice, one per source. It resolves rdy/val/tag from the register state plus the ROB forward.

## Test plan
- Reset, then issue rs1=5, rs2=0 → rdy1=1, val1=0; rdy2=1, val2=0.
- Issue rd=3 with ROB_name=7; next cycle read rs1=3 with `REG_rdy1`=0 → rdy1=0, tag1=7, `REG_ord1`=7. Then drive `REG_rdy1`=1, `REG_val1`=0x55 → rdy1=1, val1=0x55.
- Commit dest=3, tag 7, value 0xABCD → next cycle rs1=3 gives rdy1=1, val1=0xABCD, busy clear.
- Rename x3 with tag 7, then tag 9; commit tag 7 → value updated but rs1=3 still reports tag 9, not ready.
- Same cycle: commit x4 (tag 2) and issue rd=4 (tag 5) → x4 busy with tag 5, value = committed value.
- Rename x1, x2, x6, then assert `jp_wrong` with a simultaneous issue to rd=8 → all of these registers, including x8, read ready next cycle.
